// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - request/response bus between the MEM stage and data_mem_ctrl
interface data_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;
  logic                  init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err, init_done
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - MEM-stage data memory: byte-enable writes, programmable latency, clear sweep
// Optional out-of-range detection on upper address bits is enabled by defining DMEM_RANGE_CHECK_EN.
module data_mem_ctrl #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_ctrl_if.slave   bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int LSB   = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BUSY, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                init_done_q, init_done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                we_q;
  logic [IDX_W-1:0]    idx_q;
  logic                oor_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [IDX_W-1:0]    req_idx;
  logic                req_oor;
  logic                accept;
  logic                access;
  logic                acc_we;
  logic [IDX_W-1:0]    acc_idx;
  logic                acc_oor;
  logic [DATA_W-1:0]   acc_wdata;
  logic [BE_W-1:0]     acc_be;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_idx;
  logic [DATA_W-1:0]   mem_wdata;
  logic [BE_W-1:0]     mem_be;

  assign req_idx = bus.req_addr[LSB +: IDX_W];
`ifdef DMEM_RANGE_CHECK_EN
  assign req_oor = (bus.req_addr >> (LSB + IDX_W)) != '0;
`else
  assign req_oor = 1'b0;
`endif

  // With LATENCY==1 the access happens on the accept edge, so operands come straight from the bus.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we    = bus.req_we;
      acc_idx   = req_idx;
      acc_oor   = req_oor;
      acc_wdata = bus.req_wdata;
      acc_be    = bus.req_be;
    end else begin
      acc_we    = we_q;
      acc_idx   = idx_q;
      acc_oor   = oor_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    accept      = 1'b0;
    access      = 1'b0;
    mem_we      = 1'b0;
    mem_idx     = acc_idx;
    mem_wdata   = acc_wdata;
    mem_be      = acc_be;

    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_idx   = ptr_q;
        mem_wdata = '0;
        mem_be    = '1;
        ptr_d     = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = S_DONE;
            access  = 1'b1;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          access  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_CLEAR;
    endcase

    if (access) begin
      err_d = acc_oor;
      if (acc_we) begin
        mem_we = !acc_oor;
      end else begin
        rdata_d = acc_oor ? '0 : mem_q[acc_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      ptr_q       <= '0;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      oor_q       <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      if (accept) begin
        we_q    <= bus.req_we;
        idx_q   <= req_idx;
        oor_q   <= req_oor;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end
    end
  end

  // Storage is not reset; the clear sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_be[i]) mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.init_done  = init_done_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed vector bench for data_mem_ctrl at LATENCY 1 and 3
module tb_data_mem_ctrl;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int DEP = 16;
  localparam int NV  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  logic v0, v1, r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_be;
  int sel;

  data_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  data_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

  assign if0.req_valid = v0;
  assign if0.req_we    = r_we;
  assign if0.req_addr  = r_addr;
  assign if0.req_wdata = r_wdata;
  assign if0.req_be    = r_be;
  assign if1.req_valid = v1;
  assign if1.req_we    = r_we;
  assign if1.req_addr  = r_addr;
  assign if1.req_wdata = r_wdata;
  assign if1.req_be    = r_be;

  data_mem_ctrl #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst0), .bus(if0));
  data_mem_ctrl #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst1), .bus(if1));

  logic          o_ready, o_valid, o_err, o_init;
  logic [DW-1:0] o_rdata;
  assign o_ready = (sel != 0) ? if1.req_ready  : if0.req_ready;
  assign o_valid = (sel != 0) ? if1.resp_valid : if0.resp_valid;
  assign o_err   = (sel != 0) ? if1.resp_err   : if0.resp_err;
  assign o_init  = (sel != 0) ? if1.init_done  : if0.init_done;
  assign o_rdata = (sel != 0) ? if1.resp_rdata : if0.resp_rdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t tbl [NV];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request on instance s and checks latency, ready-low window and one-cycle pulse.
  task automatic request(input int s, input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] rdata, output logic err);
    int n;
    int lat;
    bit rdy_low;
    sel = s; r_we = we; r_addr = addr; r_wdata = wdata; r_be = be;
    rdata = '0; err = 1'b0;
    @(negedge clk);
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready"}, {31'd0, o_ready}, 32'd1);
    if (s != 0) v1 = 1'b1; else v0 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    lat = 0;
    rdy_low = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (o_ready) rdy_low = 1'b0;
    end while (!o_valid && lat < 20);
    check({tag, " latency"}, lat, (s != 0) ? 32'd3 : 32'd1);
    check({tag, " ready_low"}, {31'd0, rdy_low}, 32'd1);
    rdata = o_rdata;
    err   = o_err;
    @(negedge clk);
    check({tag, " pulse"}, {30'd0, o_valid, o_ready}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  bit          saw_valid;

  initial begin
    tbl[0]  = '{1'b0, 32'h3C, 32'h0,        4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 32'h0C, 32'h50,       4'hF, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 32'h0C, 32'h0,        4'hF, 32'h50,       1'b0};
    tbl[3]  = '{1'b1, 32'h08, 32'h11223344, 4'hF, 32'h50,       1'b0};
    tbl[4]  = '{1'b1, 32'h08, 32'hAABBCCDD, 4'h2, 32'h50,       1'b0};
    tbl[5]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'h1122CC44, 1'b0};
    tbl[6]  = '{1'b1, 32'h0A, 32'hDEADBEEF, 4'h9, 32'h1122CC44, 1'b0};
    tbl[7]  = '{1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 32'h1122CC44, 1'b0};
    tbl[8]  = '{1'b0, 32'h0B, 32'h0,        4'hF, 32'hDE22CCEF, 1'b0};
    tbl[9]  = '{1'b1, 32'h3C, 32'h12345678, 4'hF, 32'hDE22CCEF, 1'b0};
    tbl[10] = '{1'b0, 32'h3C, 32'h0,        4'hF, 32'h12345678, 1'b0};
`ifdef DMEM_RANGE_CHECK_EN
    tbl[11] = '{1'b1, 32'h40, 32'h99,       4'hF, 32'h12345678, 1'b1};
    tbl[12] = '{1'b0, 32'h00, 32'h0,        4'hF, 32'h0,        1'b0};
    tbl[13] = '{1'b0, 32'h40, 32'h0,        4'hF, 32'h0,        1'b1};
`else
    tbl[11] = '{1'b1, 32'h40, 32'h99,       4'hF, 32'h12345678, 1'b0};
    tbl[12] = '{1'b0, 32'h00, 32'h0,        4'hF, 32'h99,       1'b0};
    tbl[13] = '{1'b0, 32'h40, 32'h0,        4'hF, 32'h99,       1'b0};
`endif
    tbl[14] = '{1'b0, 32'h04, 32'h0,        4'hF, 32'h0,        1'b0};
    tbl[15] = '{1'b0, 32'h3C, 32'h0,        4'hF, 32'h12345678, 1'b0};

    sel = 0; v0 = 1'b0; v1 = 1'b0;
    r_we = 1'b0; r_addr = '0; r_wdata = '0; r_be = '0;
    rst0 = 1'b1; rst1 = 1'b1;
    @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      check($sformatf("rst%0d ready", s), {31'd0, o_ready}, 32'd0);
      check($sformatf("rst%0d valid", s), {31'd0, o_valid}, 32'd0);
      check($sformatf("rst%0d rdata", s), o_rdata, 32'd0);
      check($sformatf("rst%0d err", s), {31'd0, o_err}, 32'd0);
      check($sformatf("rst%0d init", s), {31'd0, o_init}, 32'd0);
    end

    // A write held valid during the sweep must be ignored.
    sel = 0; r_we = 1'b1; r_addr = 32'h3C; r_wdata = 32'h55; r_be = 4'hF; v0 = 1'b1;
    for (int k = 1; k <= DEP; k++) begin
      @(posedge clk);
      #1;
      if (k == DEP - 1) begin
        check("init_before", {31'd0, o_init}, 32'd0);
        check("ready_before", {31'd0, o_ready}, 32'd0);
      end
      if (k == DEP) begin
        check("init_after", {31'd0, o_init}, 32'd1);
        check("ready_after", {31'd0, o_ready}, 32'd1);
      end
    end
    v0 = 1'b0;

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < NV; i++) begin
        request(s, $sformatf("v%0d_%0d", s, i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er);
        check($sformatf("v%0d_%0d rdata", s, i), rd, tbl[i].exp_rdata);
        check($sformatf("v%0d_%0d err", s, i), {31'd0, er}, {31'd0, tbl[i].exp_err});
      end
    end

    // Reset during BUSY of a write on the LATENCY=3 instance.
    sel = 1; r_we = 1'b1; r_addr = 32'h04; r_wdata = 32'h77; r_be = 4'hF;
    @(negedge clk);
    v1 = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    @(negedge clk);
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    check("abort rdata", o_rdata, 32'd0);
    check("abort init", {31'd0, o_init}, 32'd0);
    saw_valid = 1'b0;
    for (int k = 0; k < 40 && !o_init; k++) begin
      @(negedge clk);
      if (o_valid) saw_valid = 1'b1;
    end
    check("abort no_resp", {31'd0, saw_valid}, 32'd0);
    check("abort reinit", {31'd0, o_init}, 32'd1);
    request(1, "abort_rd", 1'b0, 32'h04, 32'h0, 4'hF, rd, er);
    check("abort_rd rdata", rd, 32'd0);
    check("abort_rd err", {31'd0, er}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
